// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: three-stage BT.601 full-range YCbCr -> RGB converter, valid/ready with one global stall.
// Define YCBCR2RGB_SATCNT_EN to add the per-pixel clamp flag and the sat_clr/sat_count counter.
module ycbcr2rgb #(
  parameter int FRAC_BITS = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data
`ifdef YCBCR2RGB_SATCNT_EN
  ,
  input  logic        sat_clr,
  output logic [15:0] sat_count
`endif
);

  localparam logic signed [23:0] K_R_CR = 24'sd11485;
  localparam logic signed [23:0] K_G_CB = 24'sd2819;
  localparam logic signed [23:0] K_G_CR = 24'sd5850;
  localparam logic signed [23:0] K_B_CB = 24'sd14516;
  localparam logic signed [23:0] RND    = 24'sd1 <<< (FRAC_BITS - 1);

  logic adv;
  logic v1, v2, v3;

  logic              [7:0]  y1;
  logic signed       [8:0]  dcb1, dcr1;
  logic signed       [8:0]  dcb_in, dcr_in;

  logic signed       [23:0] ys2, p_r_cr2, p_g_cb2, p_g_cr2, p_b_cb2;
  logic signed       [23:0] ys_n, p_r_cr_n, p_g_cb_n, p_g_cr_n, p_b_cb_n;

  logic signed       [23:0] s_r, s_g, s_b;
  logic              [7:0]  r3, g3, b3;

  // A negative pre-rounding sum is treated as clamped even when it would round to zero.
  function automatic logic [7:0] clamp8(input logic signed [23:0] s);
    logic signed [23:0] q;
    q = (s + RND) >>> FRAC_BITS;
    if (s[23])               clamp8 = 8'd0;
    else if (q > 24'sd255)   clamp8 = 8'hFF;
    else                     clamp8 = q[7:0];
  endfunction

  assign adv       = !v3 | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign out_data  = {b3, g3, r3};

  assign dcb_in = $signed({1'b0, in_data[15:8]} - 9'd128);
  assign dcr_in = $signed({1'b0, in_data[23:16]} - 9'd128);

  assign ys_n     = $signed(24'(y1) << FRAC_BITS);
  assign p_r_cr_n = 24'(dcr1) * K_R_CR;
  assign p_g_cb_n = 24'(dcb1) * K_G_CB;
  assign p_g_cr_n = 24'(dcr1) * K_G_CR;
  assign p_b_cb_n = 24'(dcb1) * K_B_CB;

  assign s_r = ys2 + p_r_cr2;
  assign s_g = ys2 - p_g_cb2 - p_g_cr2;
  assign s_b = ys2 + p_b_cb2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      y1      <= '0;
      dcb1    <= '0;
      dcr1    <= '0;
      ys2     <= '0;
      p_r_cr2 <= '0;
      p_g_cb2 <= '0;
      p_g_cr2 <= '0;
      p_b_cb2 <= '0;
      r3      <= '0;
      g3      <= '0;
      b3      <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) begin
        y1   <= in_data[7:0];
        dcb1 <= dcb_in;
        dcr1 <= dcr_in;
      end
      if (v1) begin
        ys2     <= ys_n;
        p_r_cr2 <= p_r_cr_n;
        p_g_cb2 <= p_g_cb_n;
        p_g_cr2 <= p_g_cr_n;
        p_b_cb2 <= p_b_cb_n;
      end
      if (v2) begin
        r3 <= clamp8(s_r);
        g3 <= clamp8(s_g);
        b3 <= clamp8(s_b);
      end
    end
  end

`ifdef YCBCR2RGB_SATCNT_EN
  logic sat3;
  logic sat_n;

  function automatic logic clamped(input logic signed [23:0] s);
    logic signed [23:0] q;
    q = (s + RND) >>> FRAC_BITS;
    clamped = s[23] | (q > 24'sd255);
  endfunction

  assign sat_n = clamped(s_r) | clamped(s_g) | clamped(s_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat3 <= 1'b0;
    end else if (adv && v2) begin
      sat3 <= sat_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (v3 && out_ready && sat3 && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed self-checking bench for ycbcr2rgb; inputs change and outputs are sampled on the falling edge.
// Counter scenarios run only when YCBCR2RGB_SATCNT_EN is defined.
module tb_ycbcr2rgb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
`ifdef YCBCR2RGB_SATCNT_EN
  logic        sat_clr = 1'b0;
  logic [15:0] sat_count;
`endif

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ycbcr2rgb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef YCBCR2RGB_SATCNT_EN
    ,
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
`endif
  );

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #10;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 24'h0) $display("FAIL reset_out_data got %h exp 000000", out_data); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
`ifdef YCBCR2RGB_SATCNT_EN
    n_checks++; if (sat_count !== 16'h0) $display("FAIL reset_sat_count got %h exp 0000", sat_count); else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mid_grey;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 24'h808080;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== (k == 3)) $display("FAIL grey_valid k=%0d got %b exp %b", k, out_valid, (k == 3));
      else n_pass++;
      if (k == 3) begin
        n_checks++;
        if (out_data !== 24'h808080) $display("FAIL grey_data got %h exp 808080", out_data); else n_pass++;
      end
    end
  endtask

  task automatic test_saturation;
    logic [23:0] pin  [3];
    logic [23:0] pexp [3];
    pin[0] = 24'hFF80FF; pexp[0] = 24'hFFA4FF;
    pin[1] = 24'h000000; pexp[1] = 24'h008700;
    pin[2] = 24'hFF554C; pexp[2] = 24'h0000FE;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pin[i];
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      // last pixel driven at k=0 of this loop; first pixel is visible at k=1
      n_checks++;
      if (out_valid !== (k <= 3)) $display("FAIL sat_valid k=%0d got %b exp %b", k, out_valid, (k <= 3));
      else n_pass++;
      if (k <= 3) begin
        n_checks++;
        if (out_data !== pexp[k-1]) $display("FAIL sat_data k=%0d got %h exp %h", k, out_data, pexp[k-1]);
        else n_pass++;
      end
    end
`ifdef YCBCR2RGB_SATCNT_EN
    n_checks++; if (sat_count !== 16'd3) $display("FAIL sat_count3 got %0d exp 3", sat_count); else n_pass++;
`endif
  endtask

  task automatic test_backpressure;
    int idx_in  = 0;
    int idx_out = 0;
    logic [7:0]  yv;
    logic [23:0] ev;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 8);
      in_valid  = (idx_in < 8);
      yv        = 8'(8'h10 * (idx_in + 1));
      in_data   = {16'h8080, yv};
      #1;
      n_checks++;
      if (in_ready !== !(c >= 4 && c <= 8)) $display("FAIL bp_in_ready c=%0d got %b exp %b", c, in_ready, !(c >= 4 && c <= 8));
      else n_pass++;
      if (out_valid) begin
        yv = 8'(8'h10 * (idx_out + 1));
        ev = {yv, yv, yv};
        n_checks++;
        if (idx_out >= 8) $display("FAIL bp_extra_output c=%0d got %h exp none", c, out_data);
        else if (out_data !== ev) $display("FAIL bp_data c=%0d got %h exp %h", c, out_data, ev);
        else n_pass++;
        if (out_ready) idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (idx_out !== 8) $display("FAIL bp_out_count got %0d exp 8", idx_out); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_bubbles;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 24'hC89664;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      in_valid = (k == 2);
      in_data  = (k == 2) ? 24'h6E6432 : 24'h0;
      #1;
      n_checks++;
      if (out_valid !== (k == 3 || k == 5)) $display("FAIL bub_valid k=%0d got %b exp %b", k, out_valid, (k == 3 || k == 5));
      else n_pass++;
      if (k == 3) begin
        n_checks++; if (out_data !== 24'h8B29C9) $display("FAIL bub_data_a got %h exp 8b29c9", out_data); else n_pass++;
      end
      if (k == 5) begin
        n_checks++; if (out_data !== 24'h004819) $display("FAIL bub_data_b got %h exp 004819", out_data); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 24'h808020 + 24'(k * 16);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rm_pre_valid got %b exp 1", out_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rm_async_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 24'h0) $display("FAIL rm_async_data got %h exp 000000", out_data); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 24'h808080;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== (k == 3)) $display("FAIL rm_post_valid k=%0d got %b exp %b", k, out_valid, (k == 3));
      else n_pass++;
      if (k == 3) begin
        n_checks++; if (out_data !== 24'h808080) $display("FAIL rm_post_data got %h exp 808080", out_data); else n_pass++;
      end
    end
  endtask

`ifdef YCBCR2RGB_SATCNT_EN
  task automatic test_sat_counter;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 24'hFF80FF;
    repeat (65540) @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++; if (sat_count !== 16'hFFFF) $display("FAIL cnt_saturate got %h exp ffff", sat_count); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL cnt_clr_setup got %b exp 1", out_valid); else n_pass++;
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    #1;
    n_checks++; if (sat_count !== 16'h0) $display("FAIL cnt_clr_wins got %h exp 0000", sat_count); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (sat_count !== 16'h1) $display("FAIL cnt_after_clr got %h exp 0001", sat_count); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_mid_grey();
    test_saturation();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
`ifdef YCBCR2RGB_SATCNT_EN
    test_sat_counter();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
